// File: rtl/load_store_unit_if.sv
// Request/response, memory-side and stall signals shared between the execute stage,
// the load/store unit and the instruction/data memory arbiter.
interface load_store_unit_if #(
  parameter int ADDR_W = 10
);
  logic              req_valid;
  logic              req_ready;
  logic              req_is_store;
  logic [2:0]        req_funct3;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;
  logic [4:0]        req_rd;
  logic              stall_pc;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rw_mode;
  logic [31:0]       mem_write_data;
  logic [3:0]        mem_byte_en;
  logic [31:0]       mem_read_data;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic [4:0]        resp_rd;
  logic              resp_err;

  // Environment side: execute stage plus the arbiter's read-data return path.
  modport master (
    output req_valid, req_is_store, req_funct3, req_addr, req_wdata, req_rd, mem_read_data,
    input  req_ready, stall_pc, mem_addr, mem_rw_mode, mem_write_data, mem_byte_en,
    input  resp_valid, resp_rdata, resp_rd, resp_err
  );

  modport slave (
    input  req_valid, req_is_store, req_funct3, req_addr, req_wdata, req_rd, mem_read_data,
    output req_ready, stall_pc, mem_addr, mem_rw_mode, mem_write_data, mem_byte_en,
    output resp_valid, resp_rdata, resp_rd, resp_err
  );
endinterface

// File: rtl/load_store_unit.sv
// RV32I load/store unit: one memory op per request, byte-lane steering, load extension,
// alignment/range/funct3 checks, and stall_pc while it owns the shared memory.
//
// state  | meaning
// IDLE   | ready for a request; error responses are issued from here
// ACCESS | address/data/byte enables on the memory; stores commit here
// WAIT   | load address held until read data is valid (READ_LATENCY cycles)
module load_store_unit #(
  parameter int ADDR_W       = 10,
  parameter int READ_LATENCY = 1
) (
  input logic clk,
  input logic rst,
  load_store_unit_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACCESS, WAIT} state_t;

  state_t            state, state_nxt;
  logic              is_store_q;
  logic [2:0]        funct3_q;
  logic [ADDR_W-1:0] waddr_q;
  logic [1:0]        boff_q;
  logic [31:0]       wdata_q;
  logic [4:0]        rd_q;
  logic [2:0]        cnt;
  logic              resp_valid_q, resp_err_q;
  logic [31:0]       resp_rdata_q;
  logic [4:0]        resp_rd_q;

  logic        accept, req_err, busy, last_wait;
  logic [3:0]  byte_en;
  logic [31:0] store_data, shifted, load_val;

  assign bus.req_ready = (state == IDLE) && !rst;
  assign accept        = bus.req_valid && bus.req_ready;
  assign busy          = (state != IDLE) && !rst;
  assign last_wait     = (state == WAIT) && (cnt == 3'd0);

  always_comb begin
    req_err = 1'b0;
    if (bus.req_addr[31:ADDR_W+2] != '0) req_err = 1'b1;
    if (bus.req_funct3[1:0] == 2'b01 && bus.req_addr[0]) req_err = 1'b1;
    if (bus.req_funct3[1:0] == 2'b10 && bus.req_addr[1:0] != 2'b00) req_err = 1'b1;
    if (bus.req_is_store) begin
      if (bus.req_funct3 > 3'd2) req_err = 1'b1;
    end else if (bus.req_funct3 == 3'd3 || bus.req_funct3 == 3'd6 || bus.req_funct3 == 3'd7) begin
      req_err = 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept && !req_err) state_nxt = ACCESS;
      ACCESS:  state_nxt = is_store_q ? IDLE : WAIT;
      WAIT:    if (cnt == 3'd0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    byte_en    = 4'hF;
    store_data = wdata_q;
    case (funct3_q[1:0])
      2'b00: begin
        byte_en    = 4'b0001 << boff_q;
        store_data = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        byte_en    = 4'b0011 << boff_q;
        store_data = {2{wdata_q[15:0]}};
      end
      default: ;
    endcase
  end

  assign shifted = bus.mem_read_data >> {boff_q, 3'b000};

  always_comb begin
    load_val = 32'h0;
    case (funct3_q)
      3'd0:    load_val = {{24{shifted[7]}}, shifted[7:0]};
      3'd1:    load_val = {{16{shifted[15]}}, shifted[15:0]};
      3'd2:    load_val = shifted;
      3'd4:    load_val = {24'h0, shifted[7:0]};
      3'd5:    load_val = {16'h0, shifted[15:0]};
      default: load_val = 32'h0;
    endcase
  end

  // Memory-side outputs are forced low whenever the unit is idle or in reset.
  assign bus.stall_pc       = busy;
  assign bus.mem_addr       = busy ? waddr_q : '0;
  assign bus.mem_byte_en    = busy ? byte_en : 4'h0;
  assign bus.mem_write_data = busy ? store_data : 32'h0;
  assign bus.mem_rw_mode    = busy && (state == ACCESS) && is_store_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      is_store_q   <= 1'b0;
      funct3_q     <= 3'd0;
      waddr_q      <= '0;
      boff_q       <= 2'd0;
      wdata_q      <= 32'h0;
      rd_q         <= 5'd0;
      cnt          <= 3'd0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'h0;
      resp_rd_q    <= 5'd0;
    end else begin
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'h0;
      resp_rd_q    <= 5'd0;
      if (accept) begin
        is_store_q <= bus.req_is_store;
        funct3_q   <= bus.req_funct3;
        waddr_q    <= bus.req_addr[ADDR_W+1:2];
        boff_q     <= bus.req_addr[1:0];
        wdata_q    <= bus.req_wdata;
        rd_q       <= bus.req_rd;
        if (req_err) begin
          resp_valid_q <= 1'b1;
          resp_err_q   <= 1'b1;
          resp_rd_q    <= bus.req_rd;
        end
      end
      if (state == ACCESS) begin
        cnt <= 3'(READ_LATENCY - 1);
        if (is_store_q) begin
          resp_valid_q <= 1'b1;
          resp_rd_q    <= rd_q;
        end
      end else if (state == WAIT && cnt != 3'd0) begin
        cnt <= cnt - 3'd1;
      end
      if (last_wait) begin
        resp_valid_q <= 1'b1;
        resp_rdata_q <= load_val;
        resp_rd_q    <= rd_q;
      end
    end
  end

  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_rd    = resp_rd_q;
endmodule
